// File: rtl/snitch_catch_arbiter.sv
// Composites snitch/seeker/background pixels, measures per-frame sprite overlap and runs the
// IDLE/CHASE/COOLDOWN game phase. Optional macro SNITCH_CATCH_FLASH_EN flashes the snitch in cooldown.
module snitch_catch_arbiter #(
  parameter int unsigned H_ACTIVE        = 640,
  parameter int unsigned V_ACTIVE        = 480,
  parameter logic [15:0] CATCH_THRESH    = 16'd50,
  parameter int unsigned CATCH_FRAMES    = 3,
  parameter int unsigned COOLDOWN_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [8:0]  row,
  input  logic [9:0]  col,
  input  logic        snitch,
  input  logic [7:0]  snitch_color,
  input  logic        seeker,
  input  logic [7:0]  seeker_color,
  input  logic [7:0]  bg_color,
  input  logic        start,
  output logic [7:0]  pixel_color,
  output logic        snitch_powerup,
  output logic        caught,
  output logic [7:0]  score,
  output logic [15:0] overlap_count,
  output logic [1:0]  phase
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StChase    = 2'd1,
    StCooldown = 2'd2
  } phase_e;

  localparam logic [3:0] CatchFrames = 4'(CATCH_FRAMES);
  localparam logic [7:0] CoolFrames  = 8'(COOLDOWN_FRAMES);

  phase_e      state_q;
  logic [7:0]  pixel_q;
  logic        powerup_q;
  logic        caught_q;
  logic [7:0]  score_q;
  logic [15:0] overlap_q;
  logic [15:0] acc_q;
  logic [3:0]  hits_q;
  logic [7:0]  cool_q;

  logic        active;
  logic        frame_end;
  logic        overlap_hit;
  logic        snitch_show;
  logic [15:0] acc_total;
  logic [3:0]  hits_inc;
  logic [7:0]  pixel_d;

  always_comb begin
    active      = (32'(row) < V_ACTIVE) && (32'(col) < H_ACTIVE);
    frame_end   = active && (32'(row) == V_ACTIVE - 1) && (32'(col) == H_ACTIVE - 1);
    overlap_hit = active && snitch && seeker && (state_q == StChase);
    // Saturate rather than wrap so a huge overlap never looks like a miss.
    acc_total   = (overlap_hit && (acc_q != 16'hFFFF)) ? acc_q + 16'd1 : acc_q;
    hits_inc    = (acc_total >= CATCH_THRESH) ? hits_q + 4'd1 : 4'd0;

    snitch_show = snitch;
`ifdef SNITCH_CATCH_FLASH_EN
    if ((state_q == StCooldown) && cool_q[3]) begin
      snitch_show = 1'b0;
    end
`endif

    pixel_d = 8'd0;
    if (active) begin
      if (snitch_show) begin
        pixel_d = snitch_color;
      end else if (seeker) begin
        pixel_d = seeker_color;
      end else begin
        pixel_d = bg_color;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      pixel_q   <= 8'd0;
      powerup_q <= 1'b0;
      caught_q  <= 1'b0;
      score_q   <= 8'd0;
      overlap_q <= 16'd0;
      acc_q     <= 16'd0;
      hits_q    <= 4'd0;
      cool_q    <= 8'd0;
    end else begin
      pixel_q  <= pixel_d;
      caught_q <= 1'b0;

      if (frame_end) begin
        overlap_q <= acc_total;
        acc_q     <= 16'd0;
      end else begin
        acc_q <= acc_total;
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q   <= StChase;
            powerup_q <= 1'b1;
            hits_q    <= 4'd0;
          end
        end
        StChase: begin
          if (frame_end) begin
            if (hits_inc == CatchFrames) begin
              caught_q  <= 1'b1;
              score_q   <= (score_q == 8'hFF) ? score_q : score_q + 8'd1;
              hits_q    <= 4'd0;
              cool_q    <= CoolFrames;
              state_q   <= StCooldown;
              powerup_q <= 1'b0;
            end else begin
              hits_q <= hits_inc;
            end
          end
        end
        StCooldown: begin
          if (frame_end) begin
            cool_q <= cool_q - 8'd1;
            if (cool_q == 8'd1) begin
              state_q   <= StChase;
              powerup_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q   <= StIdle;
          powerup_q <= 1'b0;
        end
      endcase
    end
  end

  assign pixel_color    = pixel_q;
  assign snitch_powerup = powerup_q;
  assign caught         = caught_q;
  assign score          = score_q;
  assign overlap_count  = overlap_q;
  assign phase          = state_q;

endmodule
